// File: rtl/display_arbiter_if.sv
// Display-sharing bus: requester inputs and arbiter/scanner outputs.
// master = requester side (testbench/system), slave = arbiter.
interface display_arbiter_if;
  localparam int unsigned DW = 16;

  logic          req_a;
  logic [DW-1:0] data_a;
  logic          req_b;
  logic [DW-1:0] data_b;
  logic          blank;
  logic [DW-1:0] disp_data;
  logic          disp_ena;
  logic          scan_tick;
  logic [1:0]    owner;
  logic          ack_a;
  logic          ack_b;

  modport master (
    output req_a, data_a, req_b, data_b, blank,
    input  disp_data, disp_ena, scan_tick, owner, ack_a, ack_b
  );

  modport slave (
    input  req_a, data_a, req_b, data_b, blank,
    output disp_data, disp_ena, scan_tick, owner, ack_a, ack_b
  );
endinterface

// File: rtl/display_arbiter.sv
// Two-source arbiter for the shared 4-digit 7-segment display: A has priority,
// a granted source keeps the display for HOLD_TICKS scan periods, then round-robins.
module display_arbiter #(
  parameter int unsigned TICK_DIV   = 50000,
  parameter int unsigned HOLD_TICKS = 200
) (
  input logic              clk0,
  input logic              rst,
  display_arbiter_if.slave bus
);

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned HW = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HOLD_MAX   = HW'(HOLD_TICKS);
  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_A    = 2'b01;
  localparam logic [1:0] OWN_B    = 2'b10;

  typedef enum logic [1:0] {IDLE, SHOW_A, SHOW_B} state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic [HW-1:0] hold_cnt;

  logic hold_done_c;
  logic grant_a_c;
  logic grant_b_c;
  logic go_idle_c;
  logic busy_next_c;

  // Grant/release decision; release only once the hold has fully elapsed
  always_comb begin
    hold_done_c = (hold_cnt == HOLD_MAX);
    grant_a_c   = 1'b0;
    grant_b_c   = 1'b0;
    go_idle_c   = 1'b0;
    case (state)
      IDLE: begin
        grant_a_c = bus.req_a;
        grant_b_c = ~bus.req_a & bus.req_b;
      end
      SHOW_A: begin
        if (hold_done_c) begin
          if (bus.req_b)       grant_b_c = 1'b1;
          else if (~bus.req_a) go_idle_c = 1'b1;
        end
      end
      SHOW_B: begin
        if (hold_done_c) begin
          if (bus.req_a)       grant_a_c = 1'b1;
          else if (~bus.req_b) go_idle_c = 1'b1;
        end
      end
      default: go_idle_c = 1'b1;
    endcase
    busy_next_c = grant_a_c | grant_b_c | ((state != IDLE) & ~go_idle_c);
  end

  always_ff @(posedge clk0) begin
    if (rst) begin
      state         <= IDLE;
      presc         <= '0;
      hold_cnt      <= '0;
      bus.owner     <= OWN_NONE;
      bus.disp_data <= '0;
      bus.disp_ena  <= 1'b0;
      bus.scan_tick <= 1'b0;
      bus.ack_a     <= 1'b0;
      bus.ack_b     <= 1'b0;
    end else begin
      // Free-running refresh prescaler
      presc         <= (presc == PRESC_LAST) ? '0 : presc + PW'(1);
      bus.scan_tick <= (presc == PRESC_LAST);
      bus.ack_a     <= grant_a_c;
      bus.ack_b     <= grant_b_c;
      bus.disp_ena  <= busy_next_c & ~bus.blank;

      if (grant_a_c) begin
        state         <= SHOW_A;
        bus.owner     <= OWN_A;
        bus.disp_data <= bus.data_a;
        hold_cnt      <= '0;
      end else if (grant_b_c) begin
        state         <= SHOW_B;
        bus.owner     <= OWN_B;
        bus.disp_data <= bus.data_b;
        hold_cnt      <= '0;
      end else if (go_idle_c) begin
        state     <= IDLE;
        bus.owner <= OWN_NONE;
      end else if ((state != IDLE) && bus.scan_tick) begin
        // Hold advance and live-value refresh once per scan period
        if (!hold_done_c) hold_cnt <= hold_cnt + HW'(1);
        if (state == SHOW_A && bus.req_a)      bus.disp_data <= bus.data_a;
        else if (state == SHOW_B && bus.req_b) bus.disp_data <= bus.data_b;
      end
    end
  end

endmodule

// File: tb/tb_display_arbiter.sv
// Directed bench for display_arbiter (TICK_DIV=4, HOLD_TICKS=2) with an
// ack scoreboard and a per-cycle scan_tick monitor.
module tb_display_arbiter;

  logic clk0 = 1'b0;
  logic rst  = 1'b1;
  always #5 clk0 = ~clk0;

  display_arbiter_if bus ();

  display_arbiter #(.TICK_DIV(4), .HOLD_TICKS(2)) dut (
    .clk0 (clk0),
    .rst  (rst),
    .bus  (bus.slave)
  );

  typedef struct packed {
    logic [1:0]  owner;
    logic [15:0] data;
  } grant_t;

  grant_t sb[$];
  int     errors = 0;
  int     checks = 0;
  bit     mon_on = 1'b0;
  int     ncyc   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int k);
    repeat (k) @(posedge clk0);
    #1;
  endtask

  task automatic push(input logic [1:0] own, input logic [15:0] d);
    grant_t g;
    g.owner = own;
    g.data  = d;
    sb.push_back(g);
  endtask

  // Cycles since the last reset edge; the refresh tick lands on every 4th
  always @(posedge clk0) begin
    if (rst) ncyc <= 0;
    else     ncyc <= ncyc + 1;
  end

  always @(negedge clk0) begin
    if (mon_on) begin
      check("scan_tick", 32'(bus.scan_tick), 32'((ncyc != 0) && (ncyc % 4 == 0)));
      if (bus.ack_a || bus.ack_b) begin
        if (sb.size() == 0) begin
          check("unexpected_ack", {30'd0, bus.ack_b, bus.ack_a}, 32'd0);
        end else begin
          grant_t g;
          g = sb.pop_front();
          check("ack_a",        32'(bus.ack_a),     32'(g.owner == 2'b01));
          check("ack_b",        32'(bus.ack_b),     32'(g.owner == 2'b10));
          check("ack_owner",    32'(bus.owner),     32'(g.owner));
          check("ack_data",     32'(bus.disp_data), 32'(g.data));
          check("ack_disp_ena", 32'(bus.disp_ena),  32'd1);
        end
      end
    end
  end

  initial begin
    bus.req_a  = 1'b0;
    bus.req_b  = 1'b0;
    bus.data_a = 16'h0;
    bus.data_b = 16'h0;
    bus.blank  = 1'b0;
    rst        = 1'b1;
    @(posedge clk0);
    @(posedge clk0);
    #1;
    rst    = 1'b0;
    mon_on = 1'b1;

    // Idle after reset
    step(20);
    check("idle_owner", 32'(bus.owner),     32'd0);
    check("idle_ena",   32'(bus.disp_ena),  32'd0);
    check("idle_data",  32'(bus.disp_data), 32'h0000);

    // Simultaneous requests: A first, B after A's hold
    push(2'b01, 16'h1234);
    push(2'b10, 16'hBEEF);
    bus.data_a = 16'h1234;
    bus.data_b = 16'hBEEF;
    bus.req_a  = 1'b1;
    bus.req_b  = 1'b1;
    step(1);
    check("both_owner_a", 32'(bus.owner),     32'd1);
    check("both_data_a",  32'(bus.disp_data), 32'h1234);
    check("both_ena",     32'(bus.disp_ena),  32'd1);
    bus.req_a = 1'b0;
    step(8);
    check("a_hold_kept", 32'(bus.owner), 32'd1);
    step(1);
    check("switch_owner_b", 32'(bus.owner),     32'd2);
    check("switch_data_b",  32'(bus.disp_data), 32'hBEEF);
    bus.req_b = 1'b0;
    step(7);
    check("b_hold_kept", 32'(bus.owner), 32'd2);
    step(1);
    check("b_rel_owner", 32'(bus.owner),     32'd0);
    check("b_rel_ena",   32'(bus.disp_ena),  32'd0);
    check("b_rel_data",  32'(bus.disp_data), 32'hBEEF);

    // One-cycle B request still gets a full hold, display value frozen
    push(2'b10, 16'h00C5);
    bus.data_b = 16'h00C5;
    bus.req_b  = 1'b1;
    step(1);
    check("short_b_owner", 32'(bus.owner),     32'd2);
    check("short_b_data",  32'(bus.disp_data), 32'h00C5);
    bus.req_b  = 1'b0;
    bus.data_b = 16'hFFFF;
    step(6);
    check("short_b_hold", 32'(bus.owner), 32'd2);
    step(1);
    check("short_b_idle",  32'(bus.owner),     32'd0);
    check("short_b_ena",   32'(bus.disp_ena),  32'd0);
    check("short_b_frozen", 32'(bus.disp_data), 32'h00C5);

    // Live A data reloads only on scan_tick
    push(2'b01, 16'h0001);
    bus.data_a = 16'h0001;
    bus.req_a  = 1'b1;
    step(1);
    check("live_a_owner", 32'(bus.owner),     32'd1);
    check("live_a_data0", 32'(bus.disp_data), 32'h0001);
    bus.data_a = 16'h0002;
    step(1);
    check("live_a_pre_tick", 32'(bus.disp_data), 32'h0001);
    step(1);
    check("live_a_reload", 32'(bus.disp_data), 32'h0002);

    // Blank darkens the display without disturbing ownership or hold
    bus.blank = 1'b1;
    step(1);
    check("blank_ena",   32'(bus.disp_ena), 32'd0);
    check("blank_owner", 32'(bus.owner),    32'd1);
    bus.blank = 1'b0;
    step(1);
    check("unblank_ena", 32'(bus.disp_ena), 32'd1);
    bus.req_a  = 1'b0;
    push(2'b10, 16'hA5A5);
    bus.data_b = 16'hA5A5;
    bus.req_b  = 1'b1;
    step(2);
    check("blank_hold_owner", 32'(bus.owner),     32'd1);
    check("blank_hold_data",  32'(bus.disp_data), 32'h0002);
    step(1);
    check("post_blank_owner_b", 32'(bus.owner),     32'd2);
    check("post_blank_data_b",  32'(bus.disp_data), 32'hA5A5);

    // Reset mid-grant
    step(1);
    rst       = 1'b1;
    bus.req_b = 1'b0;
    step(1);
    check("rst_owner", 32'(bus.owner),     32'd0);
    check("rst_ena",   32'(bus.disp_ena),  32'd0);
    check("rst_data",  32'(bus.disp_data), 32'h0000);
    check("rst_tick",  32'(bus.scan_tick), 32'd0);
    check("rst_acks",  {30'd0, bus.ack_b, bus.ack_a}, 32'd0);
    rst = 1'b0;
    step(3);
    check("rst_tick_early", 32'(bus.scan_tick), 32'd0);
    step(1);
    check("rst_tick_first", 32'(bus.scan_tick), 32'd1);
    step(10);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/display_arbiter.md
Name: display_arbiter

Overview:
- Shares the 4-digit multiplexed 7-segment display between two requesters.
  - Source A: correlator result, fixed high priority.
  - Source B: status/diagnostic code.
- Per clock, it decides which 16-bit value drives the digit scanner and whether the scanner is enabled.
- Generates the scanner's refresh tick.
- Once a source is granted, it holds the display for a minimum number of ticks so readouts stay legible.

Parameters:
- TICK_DIV, 50000, clk0 cycles per scan_tick period (>=2).
- HOLD_TICKS, 200, minimum scan_tick periods a granted source keeps the display (>=0).

Ports:
- clk0  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- req_a  in  1  source A requests display (level)
- data_a  in  16  source A value, 4 nibbles, digit0 = [3:0]
- req_b  in  1  source B requests display (level)
- data_b  in  16  source B value
- blank  in  1  force display dark; arbitration continues
- disp_data  out  16  value to digit scanner
- disp_ena  out  1  scanner enable (1 = digits lit)
- scan_tick  out  1  one-cycle refresh strobe to scanner
- owner  out  2  00 none, 01 A, 10 B
- ack_a  out  1  one-cycle pulse on grant to A
- ack_b  out  1  one-cycle pulse on grant to B

Behaviour:
- Decided: one clock (clk0); reset rst is synchronous, active-high. On a clk0 edge with rst=1:
  - state=IDLE, owner=00, disp_data=0, disp_ena=0.
  - scan_tick=0, ack_a=ack_b=0, prescaler=0, hold_cnt=0.
  - rst mid-operation aborts any grant with no ack.
- All outputs are registered.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps to 0.
  - scan_tick=1 in the cycle following prescaler==TICK_DIV-1, so the first pulse is exactly TICK_DIV cycles after rst drops.
  - Free-running; independent of state and blank.
- FSM states: IDLE, SHOW_A, SHOW_B.
- IDLE:
  - req_a=1 -> SHOW_A (A wins when both request).
  - Else req_b=1 -> SHOW_B.
  - Else stay.
- Grant edge (entering SHOW_x from any state):
  - owner and the matching ack_x change together, one cycle after the request is sampled; ack_x is high for exactly one cycle.
  - disp_data <= data_x.
  - hold_cnt <= 0.
- SHOW_x:
  - hold_cnt increments on each scan_tick and saturates at HOLD_TICKS.
  - While req_x=1, disp_data reloads data_x on every scan_tick. Otherwise it is frozen.
- Release is permitted only when hold_cnt==HOLD_TICKS. Then:
  - If the other source requests -> switch directly to SHOW_other (new grant edge, no IDLE cycle). This applies even if req_x is still 1; the switch gives round-robin fairness after the hold.
  - Else if req_x=0 -> IDLE, owner=00. disp_data keeps its last value.
  - Else remain in SHOW_x.
- HOLD_TICKS=0: release is evaluated from the first cycle after the grant.
- disp_ena = (state!=IDLE) & ~blank, registered, so it lags blank by 1 cycle. Toggling blank never changes state, owner or hold_cnt.
- A request dropping during the hold does not shorten the hold.
- A request that drops before being sampled is never acked.
- Simultaneous events:
  - scan_tick in the grant cycle does not increment hold_cnt (the grant clears it).
  - A reload and a release in the same cycle: the release wins; disp_data takes the new owner's data.

Test Plan (TICK_DIV=4, HOLD_TICKS=2):
- Reset then idle 20 cycles:
  - scan_tick pulses at cycles 4, 8, 12, 16, 20.
  - owner=00, disp_ena=0, disp_data=0x0000.
- req_a=1 and req_b=1 in the same cycle, data_a=0x1234, data_b=0xBEEF:
  - Next cycle: owner=01, ack_a pulses once, disp_data=0x1234, disp_ena=1.
  - After 2 scan_ticks: owner=10, ack_b pulses, disp_data=0xBEEF.
- req_b only, data_b=0x00C5, held 1 cycle:
  - Grant B; the display holds through 2 scan_ticks, then goes IDLE.
  - disp_ena=0 and disp_data stays 0x00C5.
- A granted with data_a changing 0x0001->0x0002 mid-period:
  - disp_data updates to 0x0002 only on the next scan_tick.
- blank=1 while owner=01:
  - disp_ena=0 one cycle later; owner and hold timing unchanged.
  - blank=0 restores disp_ena=1.
- rst=1 asserted while owner=10:
  - After that edge, all outputs are at reset values and no ack is issued.
  - The prescaler restarts, with the first scan_tick 4 cycles after release.
